// File: rtl/gray_seq_ctrl.sv
// Gray-code run sequencer: walks a binary counter over a programmed run and streams Gray codes over valid/ready.
// Optional GRAY_PAUSE_EN adds a pause input and a PAUSE state.
module gray_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH:0]   len,
  input  logic             out_ready,
`ifdef GRAY_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LW = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hs;

  assign hs = valid_q & out_ready;

  // Next state and next register values; all outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          dir_d   = dir;
          bin_d   = start_val;
          rem_d   = len;
          state_d = (len == LW'(0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (hs) begin
            if (rem_q == LW'(1)) begin
              state_d = S_DONE;
            end else begin
              rem_d = rem_q - LW'(1);
              bin_d = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
            end
          end
`ifdef GRAY_PAUSE_EN
          // A handshake on the pause cycle has already advanced the counter above.
          if (pause && state_d == S_RUN) state_d = S_PAUSE;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef GRAY_PAUSE_EN
      S_PAUSE: begin
        if (abort)       state_d = S_IDLE;
        else if (!pause) state_d = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    gray_d  = bin_d ^ (bin_d >> 1);
    valid_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gray_out  = gray_q;
  assign bin_out   = bin_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Randomized self-checking bench for gray_seq_ctrl (WIDTH=4) against a step-index reference model.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] start_val = '0;
  logic [4:0] len = '0;
  logic       out_ready = 1'b0;
  logic [3:0] gray_out;
  logic [3:0] bin_out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a run is the list of codes start_val +/- i for i < len.
  int m_sv, m_dir, m_len, m_idx, m_bin;
  bit m_valid, m_done;
  int hs_count;

  gray_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dir(dir),
    .start_val(start_val), .len(len), .out_ready(out_ready),
`ifdef GRAY_PAUSE_EN
    .pause(1'b0),
`endif
    .gray_out(gray_out), .bin_out(bin_out), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int code_at(input int idx);
    return (m_dir != 0 ? (m_sv - idx) : (m_sv + idx)) & 15;
  endfunction

  task automatic step(input logic s, input logic a, input logic r, input logic rn);
    start = s; abort = a; out_ready = r; rst_n = rn;
    if (!rn) begin
      m_valid = 0; m_done = 0; m_bin = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_valid) begin
      if (a) m_valid = 0;
      else if (r) begin
        hs_count++;
        if (m_idx + 1 == m_len) begin
          m_valid = 0; m_done = 1;
        end else begin
          m_idx++;
          m_bin = code_at(m_idx);
        end
      end
    end else if (s && !a) begin
      m_sv = int'(start_val); m_dir = int'(dir); m_len = int'(len);
      m_idx = 0; m_bin = m_sv;
      if (m_len == 0) m_done = 1;
      else            m_valid = 1;
    end
    @(posedge clk); #1;
    chk("bin_out", int'(bin_out), m_bin);
    chk("gray_out", int'(gray_out), m_bin ^ (m_bin >> 1));
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("busy", int'(busy), int'(m_valid | m_done));
    chk("done", int'(done), int'(m_done));
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low 3 cycles on the 2nd code
  task automatic do_run(input int sv, input int ln, input int d, input int mode,
                        input int abort_at, input int rst_at);
    int cyc;
    int low_cnt;
    logic r, a, rn;
    start_val = 4'(sv); len = 5'(ln); dir = d[0];
    hs_count = 0; cyc = 0; low_cnt = 0;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    while ((m_valid || m_done) && cyc < 300) begin
      start_val = 4'($urandom); len = 5'($urandom); dir = 1'($urandom);
      case (mode)
        1: r = 1'($urandom);
        2: begin
          r = 1'b1;
          if (m_valid && m_idx == 1 && low_cnt < 3) begin
            r = 1'b0; low_cnt++;
          end
        end
        default: r = 1'b1;
      endcase
      a  = (abort_at >= 0 && m_valid && hs_count == abort_at);
      rn = !(rst_at >= 0 && cyc == rst_at);
      step(1'($urandom), a, r, rn);
      cyc++;
    end
    if (cyc >= 300) chk("run_timeout", cyc, 0);
    if (abort_at < 0 && rst_at < 0) chk("handshakes", hs_count, ln);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    m_valid = 0; m_done = 0; m_bin = 0; m_sv = 0; m_dir = 0; m_len = 0; m_idx = 0;
    hs_count = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    do_run(0, 5, 0, 0, -1, -1);
    do_run(14, 4, 0, 0, -1, -1);
    do_run(1, 3, 1, 0, -1, -1);
    do_run(2, 3, 0, 2, -1, -1);
    do_run(5, 0, 0, 0, -1, -1);
    do_run(3, 8, 0, 0, 2, -1);
    do_run(6, 4, 0, 0, -1, -1);
    // start and abort together in IDLE: stays idle
    start_val = 4'd9; len = 5'd3;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    do_run(9, 16, 1, 0, -1, -1);
    do_run(12, 16, 0, 1, -1, -1);
    do_run(7, 10, 0, 0, -1, 4);
    do_run(11, 6, 1, 1, -1, -1);
    for (int i = 0; i < 40; i++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      do_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)),
             int'($urandom_range(0, 1)), 1, ab, -1);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
